// File: rtl/core_ctrl.sv
// core_ctrl -- multi-cycle sequencer for the RV32 core.
//
// Steps one instruction at a time through FETCH -> EXEC -> WB. It owns the
// IFU fetch handshake. It gates the PC and register-file write enables so each
// fires exactly once per retired instruction. It stops in HALT on the halt
// instruction (system opcode, funct3 = 0).
//
// Optional feature: define CORE_CTRL_WATCHDOG_EN to enable the fetch watchdog.
// With the watchdog, a FETCH that waits FETCH_TIMEOUT cycles without ifu_ready
// moves to ERR. Without it, FETCH waits indefinitely and err is tied 0.
//
// Parameters
//   FETCH_TIMEOUT  max FETCH cycles without ifu_ready (watchdog build only)
//   CNT_W          watchdog counter width, must hold FETCH_TIMEOUT
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   begin execution (sampled in IDLE only)
//   op[6:0]    in   opcode from IDU
//   func[2:0]  in   funct3 from IDU
//   exu_wen    in   EXU register-write request
//   ifu_ready  in   IFU instruction stable for current pc
//   ifu_valid  out  fetch request to IFU
//   pc_we      out  PC loads upc at next edge
//   reg_wen    out  gated register-file write enable
//   exit       out  halt reached (sticky)
//   busy       out  FETCH, EXEC or WB
//   err        out  fetch watchdog expired (sticky)
//   state[2:0] out  encoded state for debug
//   inst_cnt   out  retired instruction count
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// FETCH | ifu_valid high until ifu_ready
// EXEC  | EXU settles; halt instruction detected here
// WB    | pc_we / reg_wen strobe, instruction retires
// HALT  | exit high, terminal until reset
// ERR   | err high, terminal until reset (watchdog build only)
module core_ctrl #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic [2:0]  func,
  input  logic        exu_wen,
  input  logic        ifu_ready,
  output logic        ifu_valid,
  output logic        pc_we,
  output logic        reg_wen,
  output logic        exit,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      st;
  logic        ifu_valid_q;
  logic        pc_we_q;
  logic        exit_q;
  logic        busy_q;
  logic [31:0] cnt_q;
  logic        is_halt;

  assign is_halt = (op == OP_SYSTEM) && (func == 3'b000);

`ifdef CORE_CTRL_WATCHDOG_EN
  // The counter holds the number of FETCH cycles already spent without ready.
  // The FETCH cycle that would bring it to FETCH_TIMEOUT is the last one. A
  // ready in that same cycle still wins.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(FETCH_TIMEOUT - 1);
  logic [CNT_W-1:0] wd_q;
  logic             err_q;
  logic             wd_expire;

  assign wd_expire = (wd_q >= WD_LAST);
  assign err       = err_q;
`else
  logic [CNT_W-1:0] cfg_unused;

  assign cfg_unused = CNT_W'(FETCH_TIMEOUT);
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      ifu_valid_q <= 1'b0;
      pc_we_q     <= 1'b0;
      exit_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 32'd0;
`ifdef CORE_CTRL_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Strobes default low. exit/err are sticky and are only set, never cleared.
      ifu_valid_q <= 1'b0;
      pc_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            st          <= S_FETCH;
            ifu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef CORE_CTRL_WATCHDOG_EN
            wd_q        <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (ifu_ready) begin
            st     <= S_EXEC;
            busy_q <= 1'b1;
          end
`ifdef CORE_CTRL_WATCHDOG_EN
          else if (wd_expire) begin
            st    <= S_ERR;
            err_q <= 1'b1;
          end else begin
            wd_q        <= wd_q + 1'b1;
            ifu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
`else
          else begin
            ifu_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (is_halt) begin
            st     <= S_HALT;
            exit_q <= 1'b1;
          end else begin
            st      <= S_WB;
            pc_we_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_WB: begin
          st          <= S_FETCH;
          cnt_q       <= cnt_q + 32'd1;
          ifu_valid_q <= 1'b1;
          busy_q      <= 1'b1;
`ifdef CORE_CTRL_WATCHDOG_EN
          wd_q        <= '0;
`endif
        end
        S_HALT: st <= S_HALT;
        S_ERR:  st <= S_ERR;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign ifu_valid = ifu_valid_q;
  assign pc_we     = pc_we_q;
  // The register write is qualified by the EXU request during the WB cycle.
  assign reg_wen   = pc_we_q & exu_wen;
  assign exit      = exit_q;
  assign busy      = busy_q;
  assign state     = st;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;

`ifdef CORE_CTRL_WATCHDOG_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd4;
`ifdef CORE_CTRL_WATCHDOG_EN
  localparam logic [2:0] ST_ERR   = 3'd5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  op;
  logic [2:0]  func;
  logic        exu_wen;
  logic        ifu_ready;
  logic        ifu_valid;
  logic        pc_we;
  logic        reg_wen;
  logic        exit;
  logic        busy;
  logic        err;
  logic [2:0]  state;
  logic [31:0] inst_cnt;

  core_ctrl #(.FETCH_TIMEOUT(TB_TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .func(func),
    .exu_wen(exu_wen), .ifu_ready(ifu_ready), .ifu_valid(ifu_valid),
    .pc_we(pc_we), .reg_wen(reg_wen), .exit(exit), .busy(busy), .err(err),
    .state(state), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pc_we cycle is one retirement; pop and compare.
  initial begin : monitor
    exp_t e;
    int   last_wb;
    last_wb = -1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (reg_wen === 1'b1 && pc_we !== 1'b1)
          chk("reg_wen_without_pc_we", {31'd0, reg_wen}, 32'd0);
        if (pc_we === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("unexpected_pc_we", {31'd0, pc_we}, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("wb_reg_wen", {31'd0, reg_wen}, {31'd0, e.rw});
            chk("wb_inst_cnt", inst_cnt, e.cnt);
            if (e.gap != 0) chk("wb_gap_cycles", 32'(cyc - last_wb), 32'(e.gap));
          end
          last_wb = cyc;
        end
      end
    end
  end

  initial begin : watchdog_guard
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (state !== s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, {29'd0, state}, {29'd0, s});
  endtask

  // Drive one instruction's decode inputs during its EXEC cycle.
  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic w,
                       input logic rdy, input bit push, input logic [31:0] cnt,
                       input int gap);
    exp_t e;
    wait_state(ST_EXEC, "reach_exec");
    op = o; func = f; exu_wen = w; ifu_ready = rdy;
    if (push) begin
      e.rw = w; e.cnt = cnt; e.gap = gap;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; ifu_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : stim
    int vcnt;
    logic pc_seen;
    rst = 1'b1; start = 1'b0; op = 7'd0; func = 3'd0; exu_wen = 1'b0; ifu_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_outputs", {25'd0, ifu_valid, pc_we, reg_wen, exit, busy, err, state}, 32'd0);
    chk("reset_inst_cnt", inst_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {29'd0, state}, {29'd0, ST_IDLE});

    // Four ADDI back to back with ready tied high: WB every 3rd cycle.
    pulse_start();
    chk("start_ifu_valid", {31'd0, ifu_valid}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++)
      issue(7'h13, 3'd0, 1'b1, 1'b1, 1'b1, 32'(k), (k == 0) ? 0 : 3);
    @(negedge clk);
    chk("cnt_after_4", inst_cnt, 32'd4);
    chk("refetch_ifu_valid", {31'd0, ifu_valid}, 32'd1);

    // Store: pc_we without reg_wen. Drop ready so the next fetch waits.
    issue(7'h23, 3'd2, 1'b0, 1'b0, 1'b1, 32'd4, 3);
    @(negedge clk);
    vcnt = 0; pc_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ifu_valid === 1'b1) vcnt++;
      if (pc_we === 1'b1) pc_seen = 1'b1;
      if (i == 5) ifu_ready = 1'b1;
      @(negedge clk);
    end
    chk("delay_ifu_valid_cycles", 32'(vcnt), 32'd6);
    chk("delay_no_early_pc_we", {31'd0, pc_seen}, 32'd0);
    issue(7'h13, 3'd0, 1'b1, 1'b1, 1'b1, 32'd5, 8);
    @(negedge clk);
    chk("cnt_after_delay", inst_cnt, 32'd6);

    // Reset while in EXEC aborts the instruction.
    wait_state(ST_EXEC, "reach_exec_for_reset");
    op = 7'h13; func = 3'd0; exu_wen = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {25'd0, ifu_valid, pc_we, reg_wen, exit, busy, err, state}, 32'd0);
    chk("midrst_inst_cnt", inst_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {29'd0, state}, {29'd0, ST_IDLE});
    chk("post_rst_no_fetch", {31'd0, ifu_valid}, 32'd0);

    // System op with func!=0 retires; func==0 halts.
    pulse_start();
    issue(7'h73, 3'd1, 1'b1, 1'b1, 1'b1, 32'd0, 0);
    issue(7'h13, 3'd0, 1'b1, 1'b1, 1'b1, 32'd1, 3);
    wait_state(ST_EXEC, "reach_exec_halt");
    op = 7'h73; func = 3'd0; exu_wen = 1'b1;
    @(negedge clk);
    chk("halt_state", {29'd0, state}, {29'd0, ST_HALT});
    chk("halt_exit", {31'd0, exit}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_inst_cnt", inst_cnt, 32'd2);
    pulse_start();
    repeat (8) @(negedge clk);
    chk("halt_sticky_state", {29'd0, state}, {29'd0, ST_HALT});
    chk("halt_sticky_exit", {31'd0, exit}, 32'd1);
    chk("halt_sticky_cnt", inst_cnt, 32'd2);

    do_reset();
    chk("exit_cleared", {31'd0, exit}, 32'd0);

`ifdef CORE_CTRL_WATCHDOG_EN
    ifu_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("wd_fetch_wait", {29'd0, state}, {29'd0, ST_FETCH});
      @(negedge clk);
    end
    chk("wd_err_state", {29'd0, state}, {29'd0, ST_ERR});
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    do_reset();
    chk("wd_err_cleared", {31'd0, err}, 32'd0);
    ifu_ready = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    ifu_ready = 1'b1;
    @(negedge clk);
    chk("wd_late_ready_exec", {29'd0, state}, {29'd0, ST_EXEC});
    chk("wd_late_ready_err", {31'd0, err}, 32'd0);
    do_reset();
`endif

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the RV32 core. Steps PC, IFU, decode/execute and register-file writeback through fetch, execute and writeback phases, one instruction at a time. Owns the IFU fetch handshake, gates register-file and PC write enables so each fires exactly once per instruction, and detects the halt instruction (system opcode, func 0) to raise `exit`. Sits in `top` between the datapath blocks and their enables.

## Interface
- `FETCH_TIMEOUT`, default 255: max cycles `ifu_valid` may wait for `ifu_ready` (watchdog only).
- `CNT_W`, default 8: watchdog counter width; must hold `FETCH_TIMEOUT`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start`  in  1  begin execution; sampled only in IDLE.
- `op`  in  7  opcode from IDU.
- `func`  in  3  funct3 from IDU.
- `exu_wen`  in  1  EXU's register-write request for the current instruction.
- `ifu_ready`  in  1  IFU has `inst` stable for current `pc`.
- `ifu_valid`  out  1  fetch request to IFU.
- `pc_we`  out  1  PC loads `upc` at next edge.
- `reg_wen`  out  1  gated register-file write enable.
- `exit`  out  1  halt reached; sticky.
- `busy`  out  1  state not IDLE/HALT/ERR.
- `err`  out  1  fetch watchdog expired; sticky.
- `state`  out  3  encoded state, for debug.
- `inst_cnt`  out  32  retired instruction count.

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4, ERR=5.
- IDLE: all strobes 0. `start`=1 -> FETCH.
- FETCH: `ifu_valid`=1. `ifu_ready`=1 -> EXEC; else stay.
- EXEC: all strobes 0, EXU settles. `op`==7'b1110011 and `func`==3'b000 -> HALT (no writeback, no PC update, not counted); else -> WB.
- WB: `pc_we`=1, `reg_wen`=`exu_wen`, `inst_cnt` += 1 (wraps 0xFFFFFFFF -> 0). -> FETCH.
- HALT: `exit`=1; terminal until reset; `start` ignored.
- ERR: `err`=1; terminal until reset.
- Moore outputs decoded from state. Only exception: `reg_wen` also depends on `exu_wen`.
- `busy` = FETCH|EXEC|WB.
- `start` outside IDLE ignored. `ifu_ready` outside FETCH ignored.
- `op`/`func`/`exu_wen` are used only in EXEC/WB. IFU holds `inst` stable from `ifu_ready` through WB.

## Timing
- Reset (async assert, sync-to-clk deassert at source): state=IDLE, `inst_cnt`=0, watchdog=0. All outputs 0 immediately, `state`=0.
- Reset mid-instruction aborts it. No partial writeback. `exit`/`err` cleared.
- Per instruction: minimum 3 cycles (FETCH with ready in same cycle, EXEC, WB). Each extra FETCH wait cycle adds 1.
- `start`: edge N sampled in IDLE -> `ifu_valid`=1 from cycle N+1.
- `pc_we` and `reg_wen`: exactly one cycle per retired instruction, same cycle. The PC and register file update at the WB->FETCH edge.
- Next `ifu_valid` rises the cycle after WB.
- `exit` rises one cycle after EXEC of the halt instruction and holds.

## Configuration
- `CORE_CTRL_WATCHDOG_EN` defined:
  - Counter clears on FETCH entry and increments each FETCH cycle without `ifu_ready`.
  - On reaching `FETCH_TIMEOUT` without ready -> ERR next cycle.
  - `ifu_ready` in the same cycle the count reaches `FETCH_TIMEOUT` wins -> EXEC.
- Not defined:
  - No counter. FETCH waits indefinitely.
  - `err` tied 0. ERR unreachable.
  - `FETCH_TIMEOUT`/`CNT_W` unused.

## Test plan
- Reset then `start` pulse, `ifu_ready` tied 1, stream of 4 ADDI (`exu_wen`=1):
  - `pc_we`/`reg_wen` pulse every 3rd cycle.
  - `inst_cnt`=4 after the 4th WB.
- Store-type op with `exu_wen`=0:
  - `pc_we`=1, `reg_wen`=0 in WB.
  - `inst_cnt` increments.
- `ifu_ready` delayed 5 cycles:
  - `ifu_valid` held 6 cycles.
  - Instruction takes 8 cycles.
  - No early `pc_we`.
- Halt (`op`=0x73, `func`=0) after 2 instructions:
  - HALT state, `exit`=1 sticky, `inst_cnt`=2, no further `pc_we`.
  - `start` ignored.
- `rst` low during EXEC:
  - Outputs 0 immediately, `inst_cnt`=0.
  - After release, waits in IDLE for `start`.
- `CORE_CTRL_WATCHDOG_EN`, `FETCH_TIMEOUT`=4, `ifu_ready`=0:
  - ERR after 4 FETCH cycles, `err`=1, `busy`=0.
  - Repeat with `ifu_ready` on 4th cycle -> EXEC, `err`=0.
